// File: rtl/snake_key_direction_pkg.sv
// Shared definitions: direction codes, key indices and debouncer states.
// Helpers map a key index to its heading and give the reverse of a heading.
package snake_key_direction_pkg;

   typedef logic [1:0] dir_t;

   localparam int DIR_W = 2;
   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_RIGHT = 2'd1;
   localparam dir_t DIR_DOWN  = 2'd2;
   localparam dir_t DIR_LEFT  = 2'd3;

   localparam int NUM_KEYS  = 4;
   localparam int KEY_RIGHT = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_UP    = 2;
   localparam int KEY_LEFT  = 3;

   typedef enum logic [1:0] {
      DB_RELEASED,
      DB_PRESS_WAIT,
      DB_HELD,
      DB_RELEASE_WAIT
   } db_state_t;

   function automatic dir_t key_to_dir(input int idx);
      case (idx)
         KEY_RIGHT: return DIR_RIGHT;
         KEY_DOWN:  return DIR_DOWN;
         KEY_UP:    return DIR_UP;
         default:   return DIR_LEFT;
      endcase
   endfunction

   // Opposite headings differ by 2 (mod 4), which is just bit 1 flipped.
   function automatic dir_t opposite(input dir_t d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/snake_key_direction_if.sv
// Key/heading bundle between the board/game core (master) and the key stage (slave).
// Pure wiring; no latency or flow control of its own.
interface snake_key_direction_if;
   import snake_key_direction_pkg::*;

   logic [NUM_KEYS-1:0] keys;
   logic                move_tick;
   dir_t                direction;
   logic                dir_pending;
   logic [NUM_KEYS-1:0] key_press;
   logic                turn_reject;

   modport master (
      output keys, move_tick,
      input  direction, dir_pending, key_press, turn_reject
   );

   modport slave (
      input  keys, move_tick,
      output direction, dir_pending, key_press, turn_reject
   );
endinterface

// File: rtl/snake_key_direction_key_debounce.sv
// One key: 2-FF synchroniser plus debounce FSM; key_press pulses once per debounced press.
// Latency: 2 + DEBOUNCE_CYCLES clocks from raw press to pulse; no backpressure.
module snake_key_direction_key_debounce
   import snake_key_direction_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit KEYS_ACTIVE_LOW = 1'b1
) (
   input  logic clock,
   input  logic resetHW_n,
   input  logic key_raw,
   output logic key_press
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic           IDLE_LVL = KEYS_ACTIVE_LOW;

   logic [1:0]    sync_q;
   logic          pressed;
   db_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          stable_done;

   always_ff @(posedge clock or negedge resetHW_n) begin
      if (!resetHW_n) sync_q <= {2{IDLE_LVL}};
      else            sync_q <= {sync_q[0], key_raw};
   end

   assign pressed     = sync_q[1] ^ IDLE_LVL;
   assign stable_done = (cnt_q == CNT_LAST);
   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clock or negedge resetHW_n) begin
      if (!resetHW_n) begin
         state_q <= DB_RELEASED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      key_press = 1'b0;
      case (state_q)
         DB_RELEASED: begin
            if (pressed) begin
               state_d = DB_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         DB_PRESS_WAIT: begin
            if (!pressed) begin
               state_d = DB_RELEASED;
               cnt_d   = '0;
            end else if (stable_done) begin
               state_d   = DB_HELD;
               cnt_d     = '0;
               key_press = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DB_HELD: begin
            if (!pressed) begin
               state_d = DB_RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         DB_RELEASE_WAIT: begin
            if (pressed) begin
               state_d = DB_HELD;
               cnt_d   = '0;
            end else if (stable_done) begin
               state_d = DB_RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = DB_RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/snake_key_direction.sv
// Snake key stage: debounced presses -> heading request, held until move_tick (SNAKE_DIR_QUEUE_EN: 2-entry turn FIFO).
// Latency: key_press at 2+DEBOUNCE_CYCLES clk, commit 1 clk after move_tick; no backpressure, refused presses pulse turn_reject.
module snake_key_direction
   import snake_key_direction_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit KEYS_ACTIVE_LOW = 1'b1
) (
   input  logic                   clock,
   input  logic                   resetHW_n,
   snake_key_direction_if.slave   bus
);

   logic [NUM_KEYS-1:0] press;
   logic                req_vld;
   dir_t                req_dir;
   dir_t                dir_q;
   logic                reject_q;
   logic                commit;
   dir_t                commit_dir;
   logic                reject;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      snake_key_direction_key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .KEYS_ACTIVE_LOW (KEYS_ACTIVE_LOW)
      ) u_debounce (
         .clock     (clock),
         .resetHW_n (resetHW_n),
         .key_raw   (bus.keys[k]),
         .key_press (press[k])
      );
   end

   // Lowest key index wins; other simultaneous presses are dropped silently.
   always_comb begin
      req_vld = 1'b0;
      req_dir = DIR_UP;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press[i]) begin
            req_vld = 1'b1;
            req_dir = key_to_dir(i);
         end
      end
   end

   always_ff @(posedge clock or negedge resetHW_n) begin
      if (!resetHW_n) begin
         dir_q    <= DIR_RIGHT;
         reject_q <= 1'b0;
      end else begin
         if (commit) dir_q <= commit_dir;
         reject_q <= reject;
      end
   end

   assign bus.direction   = dir_q;
   assign bus.turn_reject = reject_q;
   assign bus.key_press   = press;

`ifdef SNAKE_DIR_QUEUE_EN
   dir_t       q0_q, q1_q, tail, ref_dir;
   logic [1:0] q_cnt_q;
   logic       pop, push, reverse, full;

   always_comb begin
      pop        = bus.move_tick && (q_cnt_q != 2'd0);
      commit     = pop;
      commit_dir = q0_q;
      tail       = (q_cnt_q == 2'd2) ? q1_q : q0_q;
      ref_dir    = (q_cnt_q == 2'd0) ? dir_q : tail;
      reverse    = req_vld && (req_dir == opposite(ref_dir));
      // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
      full       = (q_cnt_q == 2'd2) && !pop;
      reject     = req_vld && (reverse || full);
      push       = req_vld && !reverse && !full;
   end

   always_ff @(posedge clock or negedge resetHW_n) begin
      if (!resetHW_n) begin
         q0_q    <= DIR_UP;
         q1_q    <= DIR_UP;
         q_cnt_q <= 2'd0;
      end else begin
         case ({pop, push})
            2'b10: begin
               q0_q    <= q1_q;
               q_cnt_q <= q_cnt_q - 1'b1;
            end
            2'b01: begin
               if (q_cnt_q == 2'd0) q0_q <= req_dir;
               else                 q1_q <= req_dir;
               q_cnt_q <= q_cnt_q + 1'b1;
            end
            2'b11: begin
               if (q_cnt_q == 2'd1) begin
                  q0_q <= req_dir;
               end else begin
                  q0_q <= q1_q;
                  q1_q <= req_dir;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.dir_pending = (q_cnt_q != 2'd0);
`else
   dir_t pend_q, ref_dir;
   logic pend_vld_q, accept;

   // A press that lands with move_tick is checked against the heading being committed.
   always_comb begin
      commit     = bus.move_tick && pend_vld_q;
      commit_dir = pend_q;
      ref_dir    = commit ? pend_q : dir_q;
      reject     = req_vld && (req_dir == opposite(ref_dir));
      accept     = req_vld && !reject;
   end

   always_ff @(posedge clock or negedge resetHW_n) begin
      if (!resetHW_n) begin
         pend_q     <= DIR_UP;
         pend_vld_q <= 1'b0;
      end else if (accept) begin
         pend_q     <= req_dir;
         pend_vld_q <= 1'b1;
      end else if (commit) begin
         pend_vld_q <= 1'b0;
      end
   end

   assign bus.dir_pending = pend_vld_q;
`endif

endmodule

// File: tb/tb_snake_key_direction.sv
// Directed bench for snake_key_direction with DEBOUNCE_CYCLES=8, active-high keys, 20 ns clock.
// Inputs change and outputs are sampled on the falling edge.
module tb_snake_key_direction;

   localparam int DB = 8;

   logic clock = 1'b0;
   logic resetHW_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   snake_key_direction_if bus ();

   snake_key_direction #(
      .DEBOUNCE_CYCLES (DB),
      .KEYS_ACTIVE_LOW (1'b0)
   ) dut (
      .clock     (clock),
      .resetHW_n (resetHW_n),
      .bus       (bus)
   );

   always #10 clock = ~clock;

   initial begin
      #200us;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive keys and wait (bounded) for the press pulse; checks vector and latency.
   task automatic press(input logic [3:0] k, input string tag);
      int          n    = 0;
      bit          seen = 0;
      logic [3:0]  got  = 4'h0;
      bus.keys = k;
      while (n < 40 && !seen) begin
         step();
         n++;
         if (bus.key_press != 4'h0) begin
            seen = 1;
            got  = bus.key_press;
         end
      end
      check({tag, "_vec"}, {28'h0, got}, {28'h0, k});
      check({tag, "_lat"}, n, 10);
   endtask

   task automatic release_keys();
      bus.keys = 4'h0;
      repeat (DB + 6) step();
   endtask

   task automatic tick();
      bus.move_tick = 1'b1;
      step();
      bus.move_tick = 1'b0;
   endtask

   initial begin
      bit stable;
      bit early;
      resetHW_n     = 1'b0;
      bus.keys      = 4'h0;
      bus.move_tick = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_dir", bus.direction, 2'b01);
      check("rst_pend", bus.dir_pending, 1'b0);
      check("rst_press", bus.key_press, 4'h0);
      check("rst_rej", bus.turn_reject, 1'b0);
      resetHW_n = 1'b1;
      stable = 1;
      repeat (50) begin
         step();
         if (bus.direction !== 2'b01 || bus.dir_pending !== 1'b0 ||
             bus.key_press !== 4'h0 || bus.turn_reject !== 1'b0) stable = 0;
      end
      check("idle_stable", stable, 1'b1);
      tick();
      check("tick_empty_dir", bus.direction, 2'b01);

      // Reversal: heading RIGHT, press LEFT
      press(4'b1000, "rev");
      step();
      check("rev_rej", bus.turn_reject, 1'b1);
      check("rev_pend", bus.dir_pending, 1'b0);
      check("rev_dir", bus.direction, 2'b01);
      step();
      check("rev_rej_clr", bus.turn_reject, 1'b0);
      check("rev_one_pulse", bus.key_press, 4'h0);
      release_keys();

      // Clean UP press, then commit
      press(4'b0100, "up");
      step();
      check("up_pend", bus.dir_pending, 1'b1);
      check("up_dir_hold", bus.direction, 2'b01);
      tick();
      check("up_dir", bus.direction, 2'b00);
      check("up_pend_clr", bus.dir_pending, 1'b0);
      release_keys();

      // Bouncing LEFT: no pulse while toggling every 3 clocks
      early = 0;
      for (int seg = 0; seg < 10; seg++) begin
         bus.keys = (seg % 2 == 0) ? 4'b1000 : 4'b0000;
         repeat (3) begin
            step();
            if (bus.key_press !== 4'h0) early = 1;
         end
      end
      check("bounce_quiet", early, 1'b0);
      press(4'b1000, "bounce");
      step();
      check("bounce_pend", bus.dir_pending, 1'b1);
      tick();
      check("bounce_dir", bus.direction, 2'b11);
      release_keys();

      // DOWN and UP together: DOWN (lower index) wins, no reject
      press(4'b0110, "simul");
      step();
      check("simul_rej", bus.turn_reject, 1'b0);
      check("simul_pend", bus.dir_pending, 1'b1);
      tick();
      check("simul_dir", bus.direction, 2'b10);
      release_keys();

      // Back to RIGHT
      press(4'b0001, "right");
      step();
      tick();
      check("right_dir", bus.direction, 2'b01);
      release_keys();

      // UP, then LEFT, then DOWN without ticks
      press(4'b0100, "q_up");
      step();
      check("q_up_rej", bus.turn_reject, 1'b0);
      check("q_up_pend", bus.dir_pending, 1'b1);
      release_keys();
      press(4'b1000, "q_left");
      step();
`ifdef SNAKE_DIR_QUEUE_EN
      check("q_left_rej", bus.turn_reject, 1'b0);
`else
      check("q_left_rej", bus.turn_reject, 1'b1);
`endif
      release_keys();
      press(4'b0010, "q_down");
      step();
`ifdef SNAKE_DIR_QUEUE_EN
      check("q_down_rej", bus.turn_reject, 1'b1);
`else
      check("q_down_rej", bus.turn_reject, 1'b0);
`endif
      release_keys();
      tick();
`ifdef SNAKE_DIR_QUEUE_EN
      check("q_tick1_dir", bus.direction, 2'b00);
      check("q_tick1_pend", bus.dir_pending, 1'b1);
`else
      check("q_tick1_dir", bus.direction, 2'b10);
      check("q_tick1_pend", bus.dir_pending, 1'b0);
`endif
      step();
      tick();
`ifdef SNAKE_DIR_QUEUE_EN
      check("q_tick2_dir", bus.direction, 2'b11);
`else
      check("q_tick2_dir", bus.direction, 2'b10);
`endif
      check("q_tick2_pend", bus.dir_pending, 1'b0);

      // Reset with a request pending and a key mid-debounce
      press(4'b1000, "pre_rst");
      step();
      check("pre_rst_pend", bus.dir_pending, 1'b1);
      bus.keys = 4'b0001;
      repeat (6) step();
      resetHW_n = 1'b0;
      repeat (2) step();
      check("mid_rst_dir", bus.direction, 2'b01);
      check("mid_rst_pend", bus.dir_pending, 1'b0);
      bus.keys  = 4'h0;
      resetHW_n = 1'b1;
      early = 0;
      repeat (15) begin
         step();
         if (bus.key_press !== 4'h0 || bus.turn_reject !== 1'b0 || bus.dir_pending !== 1'b0)
            early = 1;
      end
      check("post_rst_quiet", early, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
